// File: rtl/pipe_hazard_sched.sv
// pipe_hazard_sched: stall/flush scheduler for the 5-stage pipeline with divider FSM and stall counter
module pipe_hazard_sched #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lw_hazard_d,
  input  logic             branch_taken_d,
  input  logic             div_start_e,
  input  logic             imem_ready_f,
  input  logic             dmem_req_m,
  input  logic             dmem_ready_m,
  input  logic             exception_m,
  output logic             en_pc,
  output logic             en_fd,
  output logic             en_de,
  output logic             en_em,
  output logic             en_mw,
  output logic             clr_fd,
  output logic             clr_de,
  output logic             clr_em,
  output logic             clr_mw,
  output logic             div_busy,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [7:0] div_cnt;
  logic mem_wait, div_stall, ex, frz, ds, lw, br;
  // one-hot rule selection; rst forces the default outputs
  always_comb begin
    mem_wait = ~imem_ready_f | (dmem_req_m & ~dmem_ready_m);
    div_stall = (state == BUSY) | ((state == IDLE) & div_start_e);
    ex = ~rst & exception_m;
    frz = ~rst & ~exception_m & mem_wait;
    ds = ~rst & ~exception_m & ~mem_wait & div_stall;
    lw = ~rst & ~exception_m & ~mem_wait & ~div_stall & lw_hazard_d;
    br = ~rst & ~exception_m & ~mem_wait & ~div_stall & ~lw_hazard_d & branch_taken_d;
    en_pc = ~(frz | ds | lw);
    en_fd = ~(frz | ds | lw);
    en_de = ~(frz | ds);
    en_em = ~frz;
    en_mw = ~frz;
    clr_fd = ex | br;
    clr_de = ex | lw;
    clr_em = ex | ds;
    clr_mw = ex;
    div_busy = ~rst & (state != IDLE);
    div_done = ~rst & (state == DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      div_cnt <= 8'd0;
      stall_cnt <= '0;
    end else begin
      if (!en_pc && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
      if (exception_m) begin
        state <= IDLE;
        div_cnt <= 8'd0;
      end else if (state == IDLE) begin
        if (div_start_e) begin
          state <= BUSY;
          div_cnt <= 8'(DIV_CYCLES - 1);
        end
      end else if (state == BUSY) begin
        div_cnt <= div_cnt - 8'd1;
        if (div_cnt == 8'd1) state <= DONE;
      end else if (!mem_wait) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_pipe_hazard_sched.sv
// tb_pipe_hazard_sched: directed vector table plus multi-cycle sequences for pipe_hazard_sched
module tb_pipe_hazard_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic lw_hazard_d, branch_taken_d, div_start_e, imem_ready_f, dmem_req_m, dmem_ready_m, exception_m;
  logic en_pc, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw, div_busy, div_done;
  logic [3:0] stall_cnt;
  logic [8:0] outs;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [6:0] in;
    logic [8:0] exp;
  } vec_t;
  vec_t vecs[12];
  // input packing: {exc, lw, br, div_start, imem_ready, dmem_req, dmem_ready}
  localparam logic [6:0] IDL = 7'b0000100;
  localparam logic [8:0] DEF = 9'b11111_0000, FRZ = 9'b00000_0000, FLU = 9'b11111_1111;
  localparam logic [8:0] LWS = 9'b00111_0100, DVS = 9'b00011_0010, BRF = 9'b11111_1000;

  pipe_hazard_sched #(.DIV_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .lw_hazard_d(lw_hazard_d), .branch_taken_d(branch_taken_d),
    .div_start_e(div_start_e), .imem_ready_f(imem_ready_f), .dmem_req_m(dmem_req_m),
    .dmem_ready_m(dmem_ready_m), .exception_m(exception_m), .en_pc(en_pc), .en_fd(en_fd),
    .en_de(en_de), .en_em(en_em), .en_mw(en_mw), .clr_fd(clr_fd), .clr_de(clr_de),
    .clr_em(clr_em), .clr_mw(clr_mw), .div_busy(div_busy), .div_done(div_done), .stall_cnt(stall_cnt)
  );
  assign outs = {en_pc, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw};
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(input logic [6:0] v);
    {exception_m, lw_hazard_d, branch_taken_d, div_start_e, imem_ready_f, dmem_req_m, dmem_ready_m} = v;
  endtask
  task automatic step(input logic [6:0] v);
    @(negedge clk);
    drive(v);
    #1;
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    drive(IDL);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{IDL, DEF};
    vecs[1]  = '{7'b0110100, LWS};
    vecs[2]  = '{7'b0010100, BRF};
    vecs[3]  = '{7'b0100100, LWS};
    vecs[4]  = '{7'b0000000, FRZ};
    vecs[5]  = '{7'b0000110, FRZ};
    vecs[6]  = '{7'b0000111, DEF};
    vecs[7]  = '{7'b1000000, FLU};
    vecs[8]  = '{7'b0001100, DVS};
    vecs[9]  = '{7'b0111100, DVS};
    vecs[10] = '{7'b1001100, FLU};
    vecs[11] = '{7'b0111000, FRZ};
    drive(IDL);
    // reset cycle: hazards asserted but outputs must stay default
    @(negedge clk);
    drive(7'b1111000);
    #1;
    chk("rst_outs", 32'(outs), 32'(DEF));
    chk("rst_busy", 32'(div_busy), 0);
    do_reset;
    for (int i = 0; i < 10; i++) begin
      step(IDL);
      chk("idle_outs", 32'(outs), 32'(DEF));
      chk("idle_busy", 32'(div_busy), 0);
      chk("idle_cnt", 32'(stall_cnt), 0);
    end
    for (int i = 0; i < 12; i++) begin
      do_reset;
      step(vecs[i].in);
      chk($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
    end
    // load-use beats branch, one stall cycle counted
    do_reset;
    step(7'b0110100);
    chk("lw_br_outs", 32'(outs), 32'(LWS));
    step(IDL);
    chk("lw_cnt", 32'(stall_cnt), 1);
    // divide with div_start held: 4 stall cycles then div_done
    do_reset;
    for (int k = 0; k < 4; k++) begin
      step(7'b0001100);
      chk("div_stall", 32'(outs), 32'(DVS));
      chk("div_done_lo", 32'(div_done), 0);
      chk("div_busy", 32'(div_busy), (k > 0) ? 1 : 0);
    end
    step(7'b0001100);
    chk("div_done", 32'(div_done), 1);
    chk("div_done_outs", 32'(outs), 32'(DEF));
    step(IDL);
    chk("div_idle", 32'(div_busy), 0);
    chk("div_cnt", 32'(stall_cnt), 4);
    // divide frozen by data memory wait: DONE held until memory ready
    do_reset;
    step(7'b0001100);
    chk("mw_start", 32'(outs), 32'(DVS));
    for (int k = 1; k <= 6; k++) begin
      step(7'b0001110);
      chk("mw_frz", 32'(outs), 32'(FRZ));
      chk("mw_done", 32'(div_done), (k >= 4) ? 1 : 0);
    end
    step(7'b0001111);
    chk("mw_rel_done", 32'(div_done), 1);
    chk("mw_rel_outs", 32'(outs), 32'(DEF));
    step(IDL);
    chk("mw_idle", 32'(div_busy), 0);
    chk("mw_cnt", 32'(stall_cnt), 7);
    // exception on second BUSY cycle during mem wait aborts the divide
    do_reset;
    step(7'b0001100);
    step(7'b0001100);
    step(7'b1001000);
    chk("exc_outs", 32'(outs), 32'(FLU));
    step(IDL);
    chk("exc_busy", 32'(div_busy), 0);
    chk("exc_outs2", 32'(outs), 32'(DEF));
    for (int k = 0; k < 6; k++) begin
      step(IDL);
      chk("exc_no_done", 32'({div_done, div_busy}), 0);
    end
    // reset while BUSY
    do_reset;
    step(7'b0001100);
    step(7'b0001100);
    chk("rb_busy", 32'(div_busy), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rb_rst_outs", 32'(outs), 32'(DEF));
    chk("rb_rst_busy", 32'(div_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(IDL);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rb_idle", 32'({div_done, div_busy}), 0);
      @(negedge clk);
    end
    // saturation of the 4-bit stall counter
    do_reset;
    for (int k = 1; k <= 20; k++) begin
      step(7'b0100100);
      if (k == 15) chk("sat_14", 32'(stall_cnt), 14);
    end
    step(IDL);
    chk("sat_15", 32'(stall_cnt), 15);
    step(IDL);
    chk("sat_hold", 32'(stall_cnt), 15);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_sched.md
Name: pipe_hazard_sched

Overview:
Central stall/flush scheduler for the 5-stage pipeline. Drives the enable and clear inputs of the PC register and the four inter-stage pipeline registers (F/D, D/E, E/M, M/W). It arbitrates five sources: exception, memory wait, multi-cycle divide, load-use and taken branch. It owns the divider-occupancy state machine and a stall-cycle performance counter.

Parameters:
DIV_CYCLES, 32, cycles the divider needs after start (legal range 2..255)
CNT_W, 32, width of the stall performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
lw_hazard_d  in  1  load in E feeds a source operand of the instruction in D
branch_taken_d  in  1  branch resolved taken in D
div_start_e  in  1  divide instruction present in E
imem_ready_f  in  1  instruction memory has data this cycle
dmem_req_m  in  1  load/store in M
dmem_ready_m  in  1  data memory completes this cycle
exception_m  in  1  instruction in M raised an exception
en_pc, en_fd, en_de, en_em, en_mw  out  1 each  register enables
clr_fd, clr_de, clr_em, clr_mw  out  1 each  register clears (bubble insert)
div_busy  out  1  divider occupied (state BUSY or DONE)
div_done  out  1  divide result valid this cycle
stall_cnt  out  CNT_W  saturating count of cycles with en_pc=0

Behaviour:
- Default (no event): all en=1, all clr=0.
- State machine IDLE/BUSY/DONE with an 8-bit down-counter div_cnt.
- Reset: state=IDLE, div_cnt=0, stall_cnt=0. During the rst cycle outputs are defaults: en=1, clr=0, div_busy=0, div_done=0.
- mem_wait = ~imem_ready_f | (dmem_req_m & ~dmem_ready_m).
- Priority, highest first; exactly one rule drives en/clr each cycle:
  1. exception_m: clr_fd=clr_de=clr_em=clr_mw=1, all en=1. Overrides mem_wait. FSM forced to IDLE next cycle; div_cnt cleared.
  2. mem_wait: all en=0, all clr=0 (full freeze). The FSM still advances (divider runs independently).
  3. Div stall (state BUSY, or IDLE with div_start_e): en_pc=en_fd=en_de=0, clr_em=1, en_mw=1.
  4. lw_hazard_d: en_pc=en_fd=0, clr_de=1; others default.
  5. branch_taken_d: clr_fd=1; others default.
- Lower-priority requests are dropped in that cycle. The producing stage re-asserts them because it is frozen or refilled.
- FSM transitions:
  - IDLE: div_start_e & ~exception_m goes to BUSY, loading div_cnt=DIV_CYCLES-1.
  - BUSY: decrement div_cnt each cycle. At div_cnt==1, go to DONE.
  - DONE: div_done=1, no div stall, so the pipeline advances and the divide leaves E. If mem_wait is high, hold DONE (div_done stays 1) until the first cycle with mem_wait=0, then go to IDLE.
  - div_start_e is ignored in BUSY and DONE, because it belongs to the same instruction.
- Divide latency: div_start_e first seen in cycle T (IDLE). Stall rule 3 applies in cycles T..T+DIV_CYCLES-1. div_done=1 in cycle T+DIV_CYCLES, when the D/E register advances.
- div_busy = (state!=IDLE).
- stall_cnt increments by 1 on each clock where en_pc=0. It saturates at all-ones and never wraps.
- Exception during BUSY: aborts the divide immediately (BUSY→IDLE). div_done is never asserted for the aborted divide.
- Reset mid-BUSY returns to IDLE on the next edge; no div_done.
- en/clr outputs are combinational from current state and inputs. FSM and counters update on posedge clk only.

Test Plan:
- Reset then idle inputs, imem_ready_f=1 → all en=1, all clr=0, div_busy=0, stall_cnt=0 for 10 cycles.
- lw_hazard_d=1 for 1 cycle with branch_taken_d=1 → en_pc=en_fd=0, clr_de=1, clr_fd=0; stall_cnt=1.
- DIV_CYCLES=4, div_start_e=1 held → en_de=0, clr_em=1 for 4 cycles; div_done=1 in cycle 5 with en_de=1; then IDLE, stall_cnt=4.
- Divide started, dmem_req_m=1, dmem_ready_m=0 for 6 cycles → full freeze (all en=0); FSM reaches DONE and holds div_done=1 until dmem_ready_m=1, then IDLE.
- Exception_m on 2nd BUSY cycle with mem_wait=1 → clr_fd/de/em/mw=1, en=1 that cycle; next cycle div_busy=0; div_done never asserted.
- CNT_W=4, continuous lw_hazard_d for 20 cycles → stall_cnt stops at 15.
